// File: rtl/alu_issue_pkg.sv
// Shared constants and types for the RV64I decode/issue stage feeding the registered ALU.
package alu_issue_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned NREGS = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

  // Everything registered toward the ALU in one issue slot.
  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            imm;
    logic [4:0]      rd;
    logic            write_back;
    logic            illegal;
  } issue_t;

  function automatic logic [XLEN-1:0] sext_upper(input logic [19:0] imm20);
    return {{(XLEN-32){imm20[19]}}, imm20, 12'b0};
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Instruction handshake, ALU result return path and issued-operand bus of the issue stage.
interface alu_issue_if;
  import alu_issue_pkg::*;

  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] alu_res;
  logic            alu_wb_en;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            imm;
  logic [4:0]      rd_o;
  logic            write_back;
  logic            illegal;

  modport master (
    output inst_valid, inst, pc, alu_res, alu_wb_en, alu_rd,
    input  inst_ready, op1, op2, funct3, funct7, imm, rd_o, write_back, illegal
  );

  modport slave (
    input  inst_valid, inst, pc, alu_res, alu_wb_en, alu_rd,
    output inst_ready, op1, op2, funct3, funct7, imm, rd_o, write_back, illegal
  );

endinterface

// File: rtl/regfile_2r1w.sv
// 32x64 register file: two asynchronous read ports, one synchronous write port, x0 reads zero.
module regfile_2r1w
  import alu_issue_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [4:0]      raddr_a_i,
  output logic [XLEN-1:0] rdata_a_o,
  input  logic [4:0]      raddr_b_i,
  output logic [XLEN-1:0] rdata_b_o,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i
);

  logic [XLEN-1:0] mem_q [NREGS];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == '0) ? '0 : mem_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : mem_q[raddr_b_i];

endmodule

// File: rtl/alu_issue.sv
// RV64I OP/OP-IMM/LUI/AUIPC decode and issue toward a registered single-cycle ALU, with a
// one-bubble RAW stall against the op currently issued and forwarding from the ALU output.
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  alu_issue_if.slave bus_io
);

  logic [31:0]     inst;
  logic [6:0]      opcode;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [2:0]      f3;
  logic            use_rs1;
  logic            use_rs2;
  logic            hazard;
  logic            inst_ready;
  logic            fire;
  logic [XLEN-1:0] rf_a;
  logic [XLEN-1:0] rf_b;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  issue_t          issue_d;
  issue_t          issue_q;

  assign inst   = bus_io.inst;
  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign f3     = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];

  regfile_2r1w u_regfile (
    .clk_i     (CLK),
    .rst_ni    (RST_N),
    .raddr_a_i (rs1),
    .rdata_a_o (rf_a),
    .raddr_b_i (rs2),
    .rdata_b_o (rf_b),
    .we_i      (bus_io.alu_wb_en),
    .waddr_i   (bus_io.alu_rd),
    .wdata_i   (bus_io.alu_res)
  );

  assign use_rs1 = (opcode == OPC_OP) || (opcode == OPC_OP_IMM);
  assign use_rs2 = (opcode == OPC_OP);

  // The producer issued last cycle is still inside the ALU; one bubble lets it reach alu_res.
  assign hazard = issue_q.write_back &&
                  ((use_rs1 && (rs1 != '0) && (rs1 == issue_q.rd)) ||
                   (use_rs2 && (rs2 != '0) && (rs2 == issue_q.rd)));

  assign inst_ready        = RST_N && !hazard;
  assign fire              = bus_io.inst_valid && inst_ready;
  assign bus_io.inst_ready = inst_ready;

  always_comb begin
    rs1_val = rf_a;
    if (rs1 == '0) begin
      rs1_val = '0;
    end else if (bus_io.alu_wb_en && (bus_io.alu_rd == rs1)) begin
      rs1_val = bus_io.alu_res;
    end
    rs2_val = rf_b;
    if (rs2 == '0) begin
      rs2_val = '0;
    end else if (bus_io.alu_wb_en && (bus_io.alu_rd == rs2)) begin
      rs2_val = bus_io.alu_res;
    end
  end

  always_comb begin
    issue_d            = issue_q;
    issue_d.write_back = 1'b0;
    issue_d.illegal    = 1'b0;
    if (fire) begin
      case (opcode)
        OPC_OP: begin
          issue_d.op1    = rs1_val;
          issue_d.op2    = rs2_val;
          issue_d.funct3 = f3;
          issue_d.funct7 = inst[31:25];
          issue_d.imm    = 1'b0;
        end
        OPC_OP_IMM: begin
          issue_d.op1    = rs1_val;
          issue_d.funct3 = f3;
          issue_d.imm    = 1'b1;
          // Shifts carry a 6-bit shamt; inst[25] belongs to shamt, not funct7.
          if ((f3 == F3_SLL) || (f3 == F3_SR)) begin
            issue_d.op2    = {{(XLEN-6){1'b0}}, inst[25:20]};
            issue_d.funct7 = {inst[31:26], 1'b0};
          end else begin
            issue_d.op2    = {{(XLEN-12){inst[31]}}, inst[31:20]};
            issue_d.funct7 = '0;
          end
        end
        OPC_LUI: begin
          issue_d.op1    = '0;
          issue_d.op2    = sext_upper(inst[31:12]);
          issue_d.funct3 = F3_ADD;
          issue_d.funct7 = '0;
          issue_d.imm    = 1'b1;
        end
        OPC_AUIPC: begin
          issue_d.op1    = bus_io.pc;
          issue_d.op2    = sext_upper(inst[31:12]);
          issue_d.funct3 = F3_ADD;
          issue_d.funct7 = '0;
          issue_d.imm    = 1'b1;
        end
        default: issue_d.illegal = 1'b1;
      endcase
      if (!issue_d.illegal) begin
        issue_d.rd         = rd;
        issue_d.write_back = (rd != '0);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      issue_q <= '0;
    end else begin
      issue_q <= issue_d;
    end
  end

  assign bus_io.op1        = issue_q.op1;
  assign bus_io.op2        = issue_q.op2;
  assign bus_io.funct3     = issue_q.funct3;
  assign bus_io.funct7     = issue_q.funct7;
  assign bus_io.imm        = issue_q.imm;
  assign bus_io.rd_o       = issue_q.rd;
  assign bus_io.write_back = issue_q.write_back;
  assign bus_io.illegal    = issue_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: a registered ALU model closes the loop, an in-order architectural model
// predicts every issued slot and the stall/ready behaviour.
module tb_alu_issue;
  import alu_issue_pkg::*;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  alu_issue_if bus ();

  alu_issue u_dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .bus_io (bus)
  );

  int checks = 0;
  int failures = 0;

  // Architectural state and expected issue slot
  logic [63:0] arch [32];
  logic [63:0] exp_op1, exp_op2;
  logic [2:0]  exp_f3;
  logic [6:0]  exp_f7;
  logic        exp_imm, exp_wb, exp_ill;
  logic [4:0]  exp_rd;
  logic        exp_ready, got_ready;
  logic [145:0] got_vec;

  assign got_vec = {bus.op1, bus.op2, bus.funct3, bus.funct7, bus.imm, bus.rd_o,
                    bus.write_back, bus.illegal};

  function automatic logic [145:0] exp_vec();
    return {exp_op1, exp_op2, exp_f3, exp_f7, exp_imm, exp_rd, exp_wb, exp_ill};
  endfunction

  // Registered single-cycle ALU sitting after the issue stage
  function automatic logic [63:0] alu_fn(input logic [63:0] a, input logic [63:0] b,
                                         input logic [2:0] f3, input logic [6:0] f7,
                                         input logic im);
    case (f3)
      3'b000:  return (f7[5] && !im) ? a - b : a + b;
      3'b001:  return a << b[5:0];
      3'b010:  return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      3'b011:  return (a < b) ? 64'd1 : 64'd0;
      3'b100:  return a ^ b;
      3'b101:  return f7[5] ? 64'($signed(a) >>> b[5:0]) : a >> b[5:0];
      3'b110:  return a | b;
      default: return a & b;
    endcase
  endfunction

  always @(posedge CLK) begin
    if (!RST_N) begin
      bus.alu_res   <= '0;
      bus.alu_wb_en <= 1'b0;
      bus.alu_rd    <= '0;
    end else begin
      bus.alu_res   <= alu_fn(bus.op1, bus.op2, bus.funct3, bus.funct7, bus.imm);
      bus.alu_wb_en <= bus.write_back;
      bus.alu_rd    <= bus.rd_o;
    end
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {im, rs1, f3, rd, OPC_OP_IMM};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] im, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {im, rd, opc};
  endfunction

  function automatic logic model_hazard(input logic [31:0] i);
    logic [6:0] opc;
    logic r1, r2;
    opc = i[6:0];
    r1 = (opc == OPC_OP || opc == OPC_OP_IMM) && (i[19:15] != 0) && (i[19:15] == exp_rd);
    r2 = (opc == OPC_OP) && (i[24:20] != 0) && (i[24:20] == exp_rd);
    return exp_wb && (r1 || r2);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) arch[r] = '0;
    exp_op1 = '0; exp_op2 = '0; exp_f3 = '0; exp_f7 = '0;
    exp_imm = 1'b0; exp_rd = '0; exp_wb = 1'b0; exp_ill = 1'b0;
  endtask

  // Executes one accepted instruction in program order
  task automatic model_accept(input logic [31:0] i, input logic [63:0] p);
    logic [63:0] a, b, res, s12;
    logic [2:0]  f3;
    logic        legal;
    f3    = i[14:12];
    s12   = {{52{i[31]}}, i[31:20]};
    a     = arch[i[19:15]];
    b     = arch[i[24:20]];
    legal = 1'b1;
    res   = '0;
    case (i[6:0])
      OPC_OP: begin
        exp_op1 = a; exp_op2 = b; exp_f3 = f3; exp_f7 = i[31:25]; exp_imm = 1'b0;
      end
      OPC_OP_IMM: begin
        if (f3 == 3'b001 || f3 == 3'b101) begin
          b = 64'(i[25:20]); exp_f7 = {i[31:26], 1'b0};
        end else begin
          b = s12; exp_f7 = '0;
        end
        exp_op1 = a; exp_op2 = b; exp_f3 = f3; exp_imm = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        a = (i[6:0] == OPC_AUIPC) ? p : 64'd0;
        b = {{32{i[31]}}, i[31:12], 12'b0};
        exp_op1 = a; exp_op2 = b; exp_f3 = 3'b000; exp_f7 = '0; exp_imm = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (i[6:0] == OPC_LUI || i[6:0] == OPC_AUIPC) begin
      res = a + b;
    end else begin
      case (f3)
        3'b000: res = (i[6:0] == OPC_OP && i[30]) ? a - b : a + b;
        3'b001: res = a << b[5:0];
        3'b010: res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
        3'b011: res = (a < b) ? 64'd1 : 64'd0;
        3'b100: res = a ^ b;
        3'b101: res = i[30] ? 64'($signed(a) >>> b[5:0]) : a >> b[5:0];
        3'b110: res = a | b;
        default: res = a & b;
      endcase
    end
    if (legal) begin
      exp_rd = i[11:7]; exp_wb = (i[11:7] != 0); exp_ill = 1'b0;
      if (exp_wb) arch[i[11:7]] = res;
    end else begin
      exp_wb = 1'b0; exp_ill = 1'b1;
    end
  endtask

  // One clock: drive at negedge, sample ready, update model at posedge, return at negedge
  task automatic step(input logic v, input logic [31:0] i, input logic [63:0] p);
    bus.inst_valid = v;
    bus.inst       = i;
    bus.pc         = p;
    #1;
    exp_ready = RST_N && !model_hazard(i);
    got_ready = bus.inst_ready;
    @(posedge CLK);
    if (!RST_N) model_reset();
    else if (v && exp_ready) model_accept(i, p);
    else begin
      exp_wb = 1'b0; exp_ill = 1'b0;
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    step(1'b0, 32'd0, 64'd0);
    checks++;
    if (got_ready !== 1'b0) begin
      failures++; $display("FAIL reset_ready_low got=%0b exp=0", got_ready);
    end
    checks++;
    if (got_vec !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", got_vec);
    end
    RST_N = 1'b1;
    step(1'b0, 32'd0, 64'd0);
    checks++;
    if (got_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready_release got=%0b exp=1", got_ready);
    end
  endtask

  task automatic test_independent();
    step(1'b1, enc_i(12'd5, 5'd0, F3_ADD, 5'd1), 64'd0);
    checks++;
    if (got_ready !== 1'b1 || bus.op1 !== 64'd0 || bus.op2 !== 64'd5 || bus.imm !== 1'b1 ||
        bus.rd_o !== 5'd1 || bus.write_back !== 1'b1) begin
      failures++;
      $display("FAIL indep_addi1 got rdy=%0b op1=%h op2=%h imm=%0b rd=%0d wb=%0b exp 1/0/5/1/1/1",
               got_ready, bus.op1, bus.op2, bus.imm, bus.rd_o, bus.write_back);
    end
    step(1'b1, enc_i(12'd7, 5'd0, F3_ADD, 5'd2), 64'd0);
    checks++;
    if (got_ready !== 1'b1 || bus.op2 !== 64'd7 || bus.rd_o !== 5'd2 || bus.write_back !== 1'b1)
    begin
      failures++;
      $display("FAIL indep_addi2 got rdy=%0b op2=%h rd=%0d wb=%0b exp 1/7/2/1",
               got_ready, bus.op2, bus.rd_o, bus.write_back);
    end
    step(1'b0, 32'd0, 64'd0);
    step(1'b0, 32'd0, 64'd0);
    step(1'b1, enc_r(7'd0, 5'd2, 5'd1, F3_ADD, 5'd10), 64'd0);
    checks++;
    if (bus.op1 !== 64'd5 || bus.op2 !== 64'd7) begin
      failures++; $display("FAIL indep_regfile got op1=%h op2=%h exp 5/7", bus.op1, bus.op2);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, enc_i(12'd5, 5'd0, F3_ADD, 5'd1), 64'd0);
    step(1'b1, enc_r(7'd0, 5'd1, 5'd1, F3_ADD, 5'd3), 64'd0);
    checks++;
    if (got_ready !== 1'b0 || bus.write_back !== 1'b0) begin
      failures++;
      $display("FAIL b2b_stall got rdy=%0b wb=%0b exp 0/0", got_ready, bus.write_back);
    end
    step(1'b1, enc_r(7'd0, 5'd1, 5'd1, F3_ADD, 5'd3), 64'd0);
    checks++;
    if (got_ready !== 1'b1 || bus.op1 !== 64'd5 || bus.op2 !== 64'd5 || bus.imm !== 1'b0 ||
        bus.rd_o !== 5'd3 || bus.write_back !== 1'b1) begin
      failures++;
      $display("FAIL b2b_forward got rdy=%0b op1=%h op2=%h imm=%0b rd=%0d wb=%0b exp 1/5/5/0/3/1",
               got_ready, bus.op1, bus.op2, bus.imm, bus.rd_o, bus.write_back);
    end
    step(1'b0, 32'd0, 64'd0);
    step(1'b0, 32'd0, 64'd0);
    step(1'b1, enc_i(12'd0, 5'd3, F3_ADD, 5'd11), 64'd0);
    checks++;
    if (bus.op1 !== 64'd10) begin
      failures++; $display("FAIL b2b_result got x3=%h exp=a", bus.op1);
    end
  endtask

  task automatic test_shift();
    step(1'b1, enc_i(12'hF00, 5'd0, F3_ADD, 5'd5), 64'd0);
    step(1'b1, enc_i({6'b010000, 6'd40}, 5'd5, F3_SR, 5'd4), 64'd0);
    checks++;
    if (got_ready !== 1'b0) begin
      failures++; $display("FAIL srai_stall got rdy=%0b exp=0", got_ready);
    end
    step(1'b1, enc_i({6'b010000, 6'd40}, 5'd5, F3_SR, 5'd4), 64'd0);
    checks++;
    if (bus.op1 !== 64'hFFFF_FFFF_FFFF_FF00 || bus.op2 !== 64'd40 ||
        bus.funct7 !== 7'b0100000 || bus.funct3 !== 3'b101 || bus.imm !== 1'b1) begin
      failures++;
      $display("FAIL srai_issue got op1=%h op2=%h f7=%b f3=%b imm=%0b exp ff..00/28/0100000/101/1",
               bus.op1, bus.op2, bus.funct7, bus.funct3, bus.imm);
    end
    step(1'b0, 32'd0, 64'd0);
    step(1'b0, 32'd0, 64'd0);
    step(1'b1, enc_i(12'd0, 5'd4, F3_ADD, 5'd12), 64'd0);
    checks++;
    if (bus.op1 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      failures++; $display("FAIL srai_result got x4=%h exp=ffffffffffffffff", bus.op1);
    end
  endtask

  task automatic test_upper();
    step(1'b1, enc_u(20'h80000, 5'd6, OPC_LUI), 64'd0);
    checks++;
    if (bus.op1 !== 64'd0 || bus.op2 !== 64'hFFFF_FFFF_8000_0000 || bus.imm !== 1'b1 ||
        bus.funct3 !== 3'd0 || bus.funct7 !== 7'd0 || bus.rd_o !== 5'd6) begin
      failures++;
      $display("FAIL lui got op1=%h op2=%h imm=%0b f3=%0d f7=%0d rd=%0d exp 0/ffffffff80000000/1/0/0/6",
               bus.op1, bus.op2, bus.imm, bus.funct3, bus.funct7, bus.rd_o);
    end
    step(1'b1, enc_u(20'h00001, 5'd7, OPC_AUIPC), 64'h1000);
    checks++;
    if (bus.op1 !== 64'h1000 || bus.op2 !== 64'h1000 || bus.rd_o !== 5'd7 ||
        bus.write_back !== 1'b1) begin
      failures++;
      $display("FAIL auipc got op1=%h op2=%h rd=%0d wb=%0b exp 1000/1000/7/1",
               bus.op1, bus.op2, bus.rd_o, bus.write_back);
    end
  endtask

  task automatic test_x0_illegal();
    step(1'b1, enc_i(12'd1, 5'd0, F3_ADD, 5'd0), 64'd0);
    checks++;
    if (bus.write_back !== 1'b0 || bus.illegal !== 1'b0) begin
      failures++;
      $display("FAIL x0_dest got wb=%0b ill=%0b exp 0/0", bus.write_back, bus.illegal);
    end
    step(1'b1, 32'h0000_2083, 64'd0);
    checks++;
    if (bus.write_back !== 1'b0 || bus.illegal !== 1'b1) begin
      failures++;
      $display("FAIL illegal_pulse got wb=%0b ill=%0b exp 0/1", bus.write_back, bus.illegal);
    end
    step(1'b0, 32'd0, 64'd0);
    checks++;
    if (bus.illegal !== 1'b0) begin
      failures++; $display("FAIL illegal_one_cycle got ill=%0b exp=0", bus.illegal);
    end
    step(1'b1, enc_r(7'd0, 5'd0, 5'd0, F3_ADD, 5'd13), 64'd0);
    checks++;
    if (bus.op1 !== 64'd0 || bus.op2 !== 64'd0 || bus.write_back !== 1'b1) begin
      failures++;
      $display("FAIL x0_reads_zero got op1=%h op2=%h wb=%0b exp 0/0/1",
               bus.op1, bus.op2, bus.write_back);
    end
  endtask

  task automatic test_reset_in_stall();
    step(1'b1, enc_i(12'd5, 5'd0, F3_ADD, 5'd1), 64'd0);
    RST_N = 1'b0;
    step(1'b1, enc_r(7'd0, 5'd1, 5'd1, F3_ADD, 5'd3), 64'd0);
    checks++;
    if (got_ready !== 1'b0 || got_vec !== '0) begin
      failures++;
      $display("FAIL rst_stall_clear got rdy=%0b out=%h exp 0/0", got_ready, got_vec);
    end
    RST_N = 1'b1;
    step(1'b1, enc_r(7'd0, 5'd1, 5'd1, F3_ADD, 5'd3), 64'd0);
    checks++;
    if (got_ready !== 1'b1 || bus.op1 !== 64'd0 || bus.op2 !== 64'd0 ||
        bus.rd_o !== 5'd3 || bus.write_back !== 1'b1) begin
      failures++;
      $display("FAIL rst_stall_after got rdy=%0b op1=%h op2=%h rd=%0d wb=%0b exp 1/0/0/3/1",
               got_ready, bus.op1, bus.op2, bus.rd_o, bus.write_back);
    end
  endtask

  task automatic test_random();
    logic [31:0] i;
    logic [63:0] p;
    logic [2:0]  f3;
    logic        v;
    int          kind;
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      f3   = 3'($urandom_range(0, 7));
      p    = {$urandom(), $urandom()};
      if (kind <= 3) begin
        i = enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? FUNCT7_ALT : 7'd0,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), f3,
                  5'($urandom_range(0, 7)));
      end else if (kind <= 6) begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          i = enc_i({(f3 == 3'd5 && $urandom_range(0, 1) == 1) ? 6'b010000 : 6'b000000,
                     6'($urandom_range(0, 63))},
                    5'($urandom_range(0, 7)), f3, 5'($urandom_range(0, 7)));
        end else begin
          i = enc_i(12'($urandom()), 5'($urandom_range(0, 7)), f3, 5'($urandom_range(0, 7)));
        end
      end else if (kind == 7) begin
        i = enc_u(20'($urandom()), 5'($urandom_range(0, 7)), OPC_LUI);
      end else if (kind == 8) begin
        i = enc_u(20'($urandom()), 5'($urandom_range(0, 7)), OPC_AUIPC);
      end else begin
        i = {$urandom()};
        i[6:0] = ($urandom_range(0, 1) == 1) ? 7'b0000011 : 7'b1100011;
      end
      v = ($urandom_range(0, 4) != 0);
      step(v, i, p);
      checks++;
      if (got_ready !== exp_ready) begin
        failures++;
        $display("FAIL rand_ready n=%0d inst=%h got=%0b exp=%0b", n, i, got_ready, exp_ready);
      end
      checks++;
      if (got_vec !== exp_vec()) begin
        failures++;
        $display("FAIL rand_issue n=%0d inst=%h got=%h exp=%h", n, i, got_vec, exp_vec());
      end
    end
  endtask

  initial begin
    bus.inst_valid = 1'b0;
    bus.inst       = '0;
    bus.pc         = '0;
    model_reset();
    @(negedge CLK);
    test_reset();
    test_independent();
    test_back_to_back();
    test_shift();
    test_upper();
    test_x0_illegal();
    test_reset_in_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
